// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel frame controller: samples qualified bits, aligns to frame_start,
// and delivers each WIDTH-bit word on a registered valid/ready output.
module s2p_frame_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             frame_start,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int SR_W = WIDTH - 1;
  localparam int CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [SR_W-1:0] sr;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] word;

  // Only the first WIDTH-1 bits need storage; the final bit joins straight from serial_in.
  assign word = {sr, serial_in};

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sr           <= '0;
      cnt          <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      sync_err     <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      sync_err <= 1'b0;

      // Acceptance clears valid; a word loaded below in the same cycle takes precedence.
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bit_en && frame_start) begin
            sr    <= SR_W'(serial_in);
            cnt   <= CW'(1);
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end

        SHIFT: begin
          if (bit_en) begin
            if (frame_start) begin
              sr       <= SR_W'(serial_in);
              cnt      <= CW'(1);
              sync_err <= 1'b1;
            end else if (cnt == LAST_BIT) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
              if (!out_valid || out_ready) begin
                parallel_out <= word;
                out_valid    <= 1'b1;
                frame_cnt    <= frame_cnt + CNT_W'(1);
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              sr  <= word[SR_W-1:0];
              cnt <= cnt + CW'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Bench for s2p_frame_ctrl: directed scenarios plus randomized traffic checked
// against a bit-queue reference model.
module tb_s2p_frame_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, serial_in, bit_en, frame_start, out_ready;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid, busy, overrun, sync_err;
  logic [CNT_W-1:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: frame contents held as a queue of received bits.
  bit               m_in_frame;
  bit               m_bits[$];
  logic [WIDTH-1:0] m_out;
  bit               m_valid, m_over, m_sync;
  logic [CNT_W-1:0] m_cnt;

  s2p_frame_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .bit_en       (bit_en),
    .frame_start  (frame_start),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun),
    .sync_err     (sync_err),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_update(input logic r, be, fs, si, rdy);
    bit               accepted;
    bit               loaded;
    logic [WIDTH-1:0] w;
    if (r) begin
      m_in_frame = 0;
      m_bits.delete();
      m_out   = '0;
      m_valid = 0;
      m_over  = 0;
      m_sync  = 0;
      m_cnt   = '0;
      return;
    end
    accepted = m_valid && rdy;
    loaded   = 0;
    m_sync   = 0;
    if (be) begin
      if (fs) begin
        m_sync = m_in_frame;
        m_bits.delete();
        m_bits.push_back(si);
        m_in_frame = 1;
      end else if (m_in_frame) begin
        m_bits.push_back(si);
        if (m_bits.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++) w[WIDTH-1-i] = m_bits[i];
          if (!m_valid || rdy) begin
            m_out   = w;
            m_valid = 1;
            m_cnt   = m_cnt + 1'b1;
            loaded  = 1;
          end else begin
            m_over = 1;
          end
          m_bits.delete();
          m_in_frame = 0;
        end
      end
    end
    if (accepted && !loaded) m_valid = 0;
  endtask

  // Drive one cycle of inputs, advance the model, settle just after the edge.
  task automatic step(input logic r, be, fs, si, rdy);
    rst = r; bit_en = be; frame_start = fs; serial_in = si; out_ready = rdy;
    @(posedge clk);
    model_update(r, be, fs, si, rdy);
    #1;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic rdy);
    for (int i = 0; i < WIDTH; i++)
      step(1'b0, 1'b1, (i == 0), w[WIDTH-1-i], rdy);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (parallel_out !== '0) begin errors++; $display("FAIL reset_pout got=%b exp=0", parallel_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync got=%b exp=0", sync_err); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", frame_cnt); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] pat = 4'b1011;
    int busy_cycles = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      step(1'b0, 1'b1, (i == 0), pat[WIDTH-1-i], 1'b1);
      if (busy === 1'b1) busy_cycles++;
    end
    checks++; if (parallel_out !== 4'b1011) begin errors++; $display("FAIL basic_pout got=%b exp=1011", parallel_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt got=%0d exp=1", frame_cnt); end
    checks++; if (busy_cycles != 3) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=3", busy_cycles); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
    checks++; if (parallel_out !== 4'b1011) begin errors++; $display("FAIL basic_pout_hold got=%b exp=1011", parallel_out); end
  endtask

  task automatic test_gaps();
    logic [WIDTH-1:0] pat = 4'b1011;
    int busy_low = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      step(1'b0, 1'b1, (i == 0), pat[WIDTH-1-i], 1'b1);
      if (i < WIDTH - 1) begin
        for (int g = 0; g < 2; g++) begin
          // Gap cycles carry junk data and a stray frame_start that must be ignored.
          step(1'b0, 1'b0, 1'b1, $urandom_range(1, 0), 1'b1);
          if (busy !== 1'b1) busy_low++;
        end
      end
    end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL gaps_busy_low got=%0d exp=0", busy_low); end
    checks++; if (parallel_out !== 4'b1011) begin errors++; $display("FAIL gaps_pout got=%b exp=1011", parallel_out); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL gaps_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_overrun();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b1011, 1'b0);
    send_frame(4'b0110, 1'b0);
    checks++; if (parallel_out !== 4'b1011) begin errors++; $display("FAIL ovr_pout got=%b exp=1011", parallel_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", out_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL ovr_cnt got=%0d exp=1", frame_cnt); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop got=%b exp=0", out_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_ready_on_final();
    logic [WIDTH-1:0] pat = 4'b0110;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b1011, 1'b0);
    for (int i = 0; i < WIDTH; i++)
      step(1'b0, 1'b1, (i == 0), pat[WIDTH-1-i], (i == WIDTH - 1));
    checks++; if (parallel_out !== 4'b0110) begin errors++; $display("FAIL rdyfin_pout got=%b exp=0110", parallel_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rdyfin_valid got=%b exp=1", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rdyfin_overrun got=%b exp=0", overrun); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL rdyfin_cnt got=%0d exp=2", frame_cnt); end
  endtask

  task automatic test_resync();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL resync_pre got=%b exp=0", sync_err); end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL resync_pulse got=%b exp=1", sync_err); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL resync_one_cycle got=%b exp=0", sync_err); end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (parallel_out !== 4'b0010) begin errors++; $display("FAIL resync_pout got=%b exp=0010", parallel_out); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL resync_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(4'b1111, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if (parallel_out !== '0) begin errors++; $display("FAIL midrst_pout got=%b exp=0", parallel_out); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", frame_cnt); end
    // A non-start bit right after reset must be ignored in IDLE.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_ignore got=%b exp=0", busy); end
    send_frame(4'b1001, 1'b1);
    checks++; if (parallel_out !== 4'b1001) begin errors++; $display("FAIL midrst_pout2 got=%b exp=1001", parallel_out); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL midrst_cnt2 got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(4'b1100, 1'b1);
    checks++; if (parallel_out !== 4'b1100) begin errors++; $display("FAIL b2b_pout1 got=%b exp=1100", parallel_out); end
    send_frame(4'b0011, 1'b1);
    checks++; if (parallel_out !== 4'b0011) begin errors++; $display("FAIL b2b_pout2 got=%b exp=0011", parallel_out); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL b2b_cnt got=%0d exp=2", frame_cnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_random();
    logic r, be, fs, si, rdy;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 4000; n++) begin
      r   = ($urandom_range(799, 0) == 0);
      be  = ($urandom_range(9, 0) < 7);
      fs  = ($urandom_range(9, 0) < 2);
      si  = $urandom_range(1, 0);
      rdy = ($urandom_range(9, 0) < 7);
      step(r, be, fs, si, rdy);
      checks++;
      if (parallel_out !== m_out || out_valid !== m_valid || busy !== m_in_frame ||
          overrun !== m_over || sync_err !== m_sync || frame_cnt !== m_cnt) begin
        errors++;
        $display("FAIL random cycle=%0d got pout=%b v=%b busy=%b ovr=%b sync=%b cnt=%0d exp pout=%b v=%b busy=%b ovr=%b sync=%b cnt=%0d",
                 n, parallel_out, out_valid, busy, overrun, sync_err, frame_cnt,
                 m_out, m_valid, m_in_frame, m_over, m_sync, m_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bit_en = 1'b0; frame_start = 1'b0; serial_in = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_ready_on_final();
    test_resync();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s2p_frame_ctrl.md
Name: s2p_frame_ctrl

Overview:
Frame-level controller for the serial-to-parallel capture path. It sequences bit sampling on a qualified strobe and aligns words to an explicit frame-start marker. Each completed WIDTH-bit word is presented on a registered valid/ready output interface, with overrun and resync error reporting. It sits between a bit-rate serial source and the word-level consumer.

Parameters:
WIDTH, 4, word length in bits; legal range 2..32
CNT_W, 8, width of the delivered-frame counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
serial_in  input  1  serial data bit, sampled only when bit_en=1
bit_en  input  1  sample strobe; one bit is consumed per cycle with bit_en=1
frame_start  input  1  marks the current serial_in bit as bit 0 of a frame; meaningful only with bit_en=1
out_ready  input  1  consumer accepts the word when out_valid=1
parallel_out  output  WIDTH  last delivered word; first-received bit at [WIDTH-1], last at [0]
out_valid  output  1  parallel_out holds an undelivered word
busy  output  1  high while in SHIFT
overrun  output  1  sticky; a completed word was dropped
sync_err  output  1  one-cycle pulse; frame_start arrived mid-frame
frame_cnt  output  CNT_W  count of words loaded into the output register; wraps at 2^CNT_W

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. Shift register, bit counter, parallel_out, out_valid, busy, overrun, sync_err and frame_cnt all go to 0. Reset overrides every other input, including mid-frame; any partial frame is discarded.
- Shift rule on a consumed bit: sr <= {sr[WIDTH-2:0], serial_in}. No shift occurs when bit_en=0, in any state.
- IDLE (busy=0):
  - bit_en=1 & frame_start=1: sr <= {0..., serial_in}, cnt <= 1, go to SHIFT.
  - All other bits are ignored, including frame_start with bit_en=0.
- SHIFT (busy=1):
  - bit_en=1 & frame_start=0 & cnt<WIDTH-1: shift, cnt++.
  - bit_en=1 & frame_start=0 & cnt==WIDTH-1: final bit. word = {sr[WIDTH-2:0], serial_in}. Go to IDLE, cnt <= 0. Output rules below apply.
  - bit_en=1 & frame_start=1: resync. sync_err pulses high for the next cycle only. Partial word discarded; sr <= {0..., serial_in}, cnt <= 1, stay in SHIFT.
  - bit_en=0: hold all state.
- Output register on final-bit cycle:
  - If out_valid=0, or out_valid=1 & out_ready=1: parallel_out <= word, out_valid <= 1, frame_cnt++.
  - If out_valid=1 & out_ready=0: word dropped, parallel_out unchanged, overrun <= 1. overrun stays set until rst.
- Handshake with no completing frame: out_valid=1 & out_ready=1 clears out_valid next cycle. parallel_out keeps its value after acceptance. out_ready is ignored when out_valid=0.
- Latency: parallel_out and out_valid update at the same edge that samples the final bit. They are visible the cycle after the final bit is presented.
- Back-to-back: a new frame may start (frame_start with bit_en) in the cycle immediately after the final bit. No dead cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- frame_cnt wraps from 2^CNT_W-1 to 0 silently.

Test Plan:
- WIDTH=4, out_ready=1, bit_en=1 every cycle; frame_start with bit 1, then bits 0,1,1 -> one cycle after the 4th bit: parallel_out=4'b1011, out_valid=1 for exactly 1 cycle, frame_cnt=1, busy high for 3 cycles.
- Same frame with bit_en low for 2 cycles between every bit -> parallel_out=4'b1011; no shift on bit_en=0 cycles; busy held throughout.
- out_ready=0; frames 1011 then 0110 back-to-back -> parallel_out stays 4'b1011, out_valid=1, overrun=1, frame_cnt=1; raise out_ready -> out_valid drops next cycle, overrun remains 1.
- out_ready=0, first frame 1011 pending; raise out_ready in the same cycle as the final bit of 0110 -> parallel_out=4'b0110, out_valid stays 1, overrun=0, frame_cnt=2.
- Bits 1,1 then frame_start with bits 0,0,1,0 -> sync_err=1 for one cycle after the resync bit; result parallel_out=4'b0010, frame_cnt=1.
- rst=1 for one cycle after 2 bits of a frame -> all outputs 0, state IDLE; a subsequent frame 1001 yields parallel_out=4'b1001, frame_cnt=1.
